lif_membrane_integrator: RTL and testbench
==========================================

// Module: lif_membrane_integrator
// PURPOSE
//   Leaky-integrate stage of the digital neuron, upstream of the V-select mux.
//   Accumulates signed synaptic current samples, applies leak once per time step,
//   and produces membrane potential v_out (21b signed Q12.9) plus a threshold spike flag.
//   Runs a fire/refractory FSM so v_out is held at v_reset for REFRAC_CYC steps after a spike.
// PARAMETERS
//   W          21  data width, signed two's complement, Q12.9 (1.0 = 0x200)
//   FRAC       9   fractional bits (documentation/bench scaling only)
//   LEAK_SHIFT 3   leak term = v >>> LEAK_SHIFT (arithmetic, rounds toward -inf)
//   REFRAC_CYC 4   refractory length in steps; 0 = no refractory period
// PORTS
//   clk         in   1  single clock, rising edge
//   rst_n       in   1  asynchronous, active-low reset
//   in_valid    in   1  in_current valid
//   in_ready    out  1  stage accepts in_current (combinational from state)
//   in_current  in   W  signed current sample
//   step        in   1  time-step tick, 1-cycle pulse
//   v_thresh    in   W  signed firing threshold (static during operation)
//   v_reset     in   W  signed post-spike potential (static during operation)
//   v_out       out  W  signed membrane potential, registered
//   v_valid     out  1  1-cycle pulse: v_out updated
//   spike       out  1  1-cycle pulse coincident with FIRE
//   refrac_busy out  1  high in REFRAC state
// BEHAVIOUR
//   Reset (async, rst_n=0): state=INTEG, v=0, acc=0, cnt=0; v_out=0, v_valid=0,
//     spike=0, refrac_busy=0, in_ready=0. After release, in_ready follows state.
//   Saturation: every add uses W+2 bits internally, then clamps to [0x100000, 0x0FFFFF].
//   in_ready = 1 in INTEG and REFRAC, 0 in FIRE. Transfer = in_valid & in_ready.
//   INTEG: each transfer does acc <= sat(acc + in_current).
//     On step: v_next = sat(v + acc_eff - (v >>> LEAK_SHIFT)), where
//     acc_eff = sat(acc + in_current) if a transfer happens in the same cycle, else acc.
//     Next cycle: v <= v_next, v_out = v_next, v_valid=1, acc <= 0.
//     If v_next >= v_thresh (signed): state -> FIRE, else stay INTEG.
//   FIRE (exactly 1 cycle): spike=1, v <= v_reset, v_out = v_reset, v_valid=1,
//     acc <= 0. step arriving in FIRE is ignored.
//     Go to REFRAC with cnt=REFRAC_CYC; if REFRAC_CYC=0, go directly to INTEG.
//   REFRAC: refrac_busy=1; transfers complete but are discarded (acc stays 0).
//     On step: cnt <= cnt-1, v_out = v_reset, v_valid=1 next cycle, no leak applied.
//     The step that brings cnt to 0 returns state to INTEG.
//     The following step integrates normally.
//   Latency: step -> v_valid exactly 1 cycle; threshold cross -> spike 2 cycles after step.
//   Steps with no transfers still apply leak (acc=0). Back-to-back steps are legal.
//   A mid-operation reset aborts any state; no spike is emitted on reset release.
// TESTING
//   1 Reset: hold rst_n=0 with in_valid=1 and step=1 -> all outputs 0, in_ready=0;
//     release -> in_ready=1, v_out=0.
//   2 Integrate: v=0, three transfers of 0x200, then step -> v_out=0x600, no spike;
//     step with no input -> v_out=0x540 (0x600-0xC0).
//   3 Fire: v=0x540, v_thresh=0xA00, v_reset=0, transfer 0x600 in same cycle as step
//     -> v_out=0xA98, v_valid; next cycle spike=1, v_out=0, in_ready=0.
//   4 Refractory: REFRAC_CYC=4, transfers of 0x400 between steps -> 4 steps give v_out=0
//     with refrac_busy=1; 5th step with one transfer 0x200 -> v_out=0x200.
//   5 Saturation: v=0x0FF000, v_thresh=0x0FFFFF, transfer 0x0FFFFF + step -> v_out=0x0FFFFF,
//     spike; v=0x100800, transfer 0x100000 -> v_out=0x100000.
//   6 Reset mid-REFRAC: pulse rst_n low after 2 refractory steps -> v_out=0,
//     refrac_busy=0, state INTEG; next step with transfer 0x200 -> v_out=0x200.

Source files
------------

// File: rtl/lif_membrane_integrator_if.sv
// Synaptic current stream into the LIF membrane integrator.
// The source drives in_valid/in_current. The integrator answers with in_ready.
interface lif_membrane_integrator_if #(
    parameter int W = 21
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_current;

    modport master (
        output in_valid,
        output in_current,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_current,
        output in_ready
    );
endinterface

// File: rtl/lif_membrane_integrator.sv
// Leaky-integrate stage of the digital neuron.
// Accumulates signed Q12.9 current samples between time steps.
// On each step, the stage folds the accumulated current into the membrane
// potential and subtracts an arithmetic-shift leak.
// A fire/refractory FSM pins the potential to v_reset for REFRAC_CYC steps
// after each spike.
module lif_membrane_integrator #(
    parameter int W          = 21,
    parameter int FRAC       = 9,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    lif_membrane_integrator_if.slave in_if,
    input  logic                step_i,
    input  logic signed [W-1:0] v_thresh_i,
    input  logic signed [W-1:0] v_reset_i,
    output logic signed [W-1:0] v_out_o,
    output logic                v_valid_o,
    output logic                spike_o,
    output logic                refrac_busy_o
);

    localparam int CNT_W = (REFRAC_CYC > 0) ? $clog2(REFRAC_CYC + 1) : 1;

    // Saturation bounds, sign-extended to the W+2 working width.
    localparam logic signed [W+1:0] MAX_EXT = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] MIN_EXT = {3'b111, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] MAX_W   = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_W   = {1'b1, {(W-1){1'b0}}};

    // FRAC only defines the scaling. A value with no integer bit is a configuration error.
    generate
        if (FRAC >= W - 1) begin : g_frac_chk
            $error("FRAC leaves no integer bits in the data word");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_INTEG  = 2'd0,
        ST_FIRE   = 2'd1,
        ST_REFRAC = 2'd2
    } state_e;

    // Sign-extend a W-bit value to the W+2 working width.
    function automatic logic signed [W+1:0] ext(input logic signed [W-1:0] a);
        return {{2{a[W-1]}}, a};
    endfunction

    // Clamp a W+2-bit result into the signed W-bit range.
    function automatic logic signed [W-1:0] sat_w(input logic signed [W+1:0] x);
        logic signed [W-1:0] r;
        if (x > MAX_EXT) begin
            r = MAX_W;
        end else if (x < MIN_EXT) begin
            r = MIN_W;
        end else begin
            r = x[W-1:0];
        end
        return r;
    endfunction

    state_e              state_q, state_d;
    logic signed [W-1:0] acc_q, acc_d;
    logic signed [W-1:0] v_q, v_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic signed [W-1:0] v_out_q, v_out_d;
    logic                v_valid_q, v_valid_d;
    logic                spike_q, spike_d;
    logic                busy_q, busy_d;
    logic                ready_en_q;

    logic                in_ready_s;
    logic                xfer_s;
    logic signed [W-1:0] acc_sum_s;
    logic signed [W-1:0] acc_eff_s;
    logic signed [W-1:0] leak_s;
    logic signed [W-1:0] v_next_s;

    // ready_en_q keeps in_ready low while reset is asserted.
    // in_ready stays low until the first clock after reset release.
    assign in_ready_s     = ready_en_q & (state_q != ST_FIRE);
    assign in_if.in_ready = in_ready_s;
    assign xfer_s         = in_if.in_valid & in_ready_s;

    // Datapath: saturated accumulate, and the leaky potential update for a step.
    always_comb begin
        acc_sum_s = sat_w(ext(acc_q) + ext(in_if.in_current));
        if (xfer_s) begin
            acc_eff_s = acc_sum_s;
        end else begin
            acc_eff_s = acc_q;
        end
        leak_s   = v_q >>> LEAK_SHIFT;
        v_next_s = sat_w(ext(v_q) + ext(acc_eff_s) - ext(leak_s));
    end

    // Next-state and next-output logic for the integrate/fire/refractory FSM.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        v_d       = v_q;
        cnt_d     = cnt_q;
        v_out_d   = v_out_q;
        v_valid_d = 1'b0;
        spike_d   = 1'b0;
        case (state_q)
            ST_INTEG: begin
                if (step_i) begin
                    v_d       = v_next_s;
                    v_out_d   = v_next_s;
                    v_valid_d = 1'b1;
                    acc_d     = '0;
                    if (v_next_s >= v_thresh_i) begin
                        state_d = ST_FIRE;
                    end else begin
                        state_d = ST_INTEG;
                    end
                end else if (xfer_s) begin
                    acc_d = acc_sum_s;
                end else begin
                    acc_d = acc_q;
                end
            end
            ST_FIRE: begin
                // A step arriving here is deliberately ignored.
                spike_d   = 1'b1;
                v_d       = v_reset_i;
                v_out_d   = v_reset_i;
                v_valid_d = 1'b1;
                acc_d     = '0;
                if (REFRAC_CYC == 0) begin
                    state_d = ST_INTEG;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_REFRAC;
                    cnt_d   = CNT_W'(REFRAC_CYC);
                end
            end
            ST_REFRAC: begin
                // Transfers still handshake here, but their data is dropped.
                acc_d = '0;
                if (step_i) begin
                    cnt_d     = cnt_q - CNT_W'(1);
                    v_out_d   = v_reset_i;
                    v_valid_d = 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_INTEG;
                    end else begin
                        state_d = ST_REFRAC;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_INTEG;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_REFRAC);
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INTEG;
            acc_q      <= '0;
            v_q        <= '0;
            cnt_q      <= '0;
            v_out_q    <= '0;
            v_valid_q  <= 1'b0;
            spike_q    <= 1'b0;
            busy_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            v_q        <= v_d;
            cnt_q      <= cnt_d;
            v_out_q    <= v_out_d;
            v_valid_q  <= v_valid_d;
            spike_q    <= spike_d;
            busy_q     <= busy_d;
            ready_en_q <= 1'b1;
        end
    end

    assign v_out_o       = v_out_q;
    assign v_valid_o     = v_valid_q;
    assign spike_o       = spike_q;
    assign refrac_busy_o = busy_q;

endmodule

// File: tb/tb_lif_membrane_integrator.sv
// Directed bench for lif_membrane_integrator.
// Expected values are hand-computed Q12.9 numbers.
module tb_lif_membrane_integrator;

    logic               clk;
    logic               rst_n;
    logic               step;
    logic signed [20:0] v_thresh;
    logic signed [20:0] v_reset;
    logic signed [20:0] v_out;
    logic               v_valid;
    logic               spike;
    logic               refrac_busy;

    int errors;
    int checks;

    lif_membrane_integrator_if #(.W(21)) bus ();

    lif_membrane_integrator #(
        .W(21), .FRAC(9), .LEAK_SHIFT(3), .REFRAC_CYC(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_if         (bus.slave),
        .step_i        (step),
        .v_thresh_i    (v_thresh),
        .v_reset_i     (v_reset),
        .v_out_o       (v_out),
        .v_valid_o     (v_valid),
        .spike_o       (spike),
        .refrac_busy_o (refrac_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    // One clock of stimulus. Outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic vld, input logic [20:0] cur, input logic stp);
        bus.in_valid   = vld;
        bus.in_current = cur;
        step           = stp;
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        step           = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_current = 21'h000200;
        step = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (v_out !== 21'h000000) begin errors++; $display("FAIL rst_v_out: got %h want 000000", v_out); end
        checks++; if (v_valid !== 1'b0) begin errors++; $display("FAIL rst_v_valid: got %b want 0", v_valid); end
        checks++; if (spike !== 1'b0) begin errors++; $display("FAIL rst_spike: got %b want 0", spike); end
        checks++; if (refrac_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", refrac_busy); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        bus.in_valid = 1'b0;
        step = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (v_out !== 21'h000000) begin errors++; $display("FAIL rel_v_out: got %h want 000000", v_out); end
    endtask

    task automatic test_integrate();
        v_thresh = 21'h000A00;
        v_reset  = 21'h000000;
        for (int i = 0; i < 3; i++) drive(1'b1, 21'h000200, 1'b0);
        checks++; if (v_valid !== 1'b0) begin errors++; $display("FAIL integ_no_valid: got %b want 0", v_valid); end
        drive(1'b0, 21'h000000, 1'b1);
        checks++; if (v_out !== 21'h000600) begin errors++; $display("FAIL integ_v: got %h want 000600", v_out); end
        checks++; if (v_valid !== 1'b1) begin errors++; $display("FAIL integ_valid: got %b want 1", v_valid); end
        drive(1'b0, 21'h000000, 1'b0);
        checks++; if (spike !== 1'b0) begin errors++; $display("FAIL integ_spike: got %b want 0", spike); end
        checks++; if (v_valid !== 1'b0) begin errors++; $display("FAIL integ_pulse: got %b want 0", v_valid); end
        drive(1'b0, 21'h000000, 1'b1);
        checks++; if (v_out !== 21'h000540) begin errors++; $display("FAIL leak_v: got %h want 000540", v_out); end
    endtask

    task automatic test_fire();
        drive(1'b1, 21'h000600, 1'b1);
        checks++; if (v_out !== 21'h000A98) begin errors++; $display("FAIL fire_v: got %h want 000a98", v_out); end
        checks++; if (v_valid !== 1'b1) begin errors++; $display("FAIL fire_valid: got %b want 1", v_valid); end
        checks++; if (spike !== 1'b0) begin errors++; $display("FAIL fire_early_spike: got %b want 0", spike); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fire_in_ready: got %b want 0", bus.in_ready); end
        // This step lands in the fire cycle and must be ignored.
        drive(1'b0, 21'h000000, 1'b1);
        checks++; if (spike !== 1'b1) begin errors++; $display("FAIL fire_spike: got %b want 1", spike); end
        checks++; if (v_out !== 21'h000000) begin errors++; $display("FAIL fire_v_reset: got %h want 000000", v_out); end
        checks++; if (v_valid !== 1'b1) begin errors++; $display("FAIL fire_reset_valid: got %b want 1", v_valid); end
        checks++; if (refrac_busy !== 1'b1) begin errors++; $display("FAIL fire_busy: got %b want 1", refrac_busy); end
    endtask

    task automatic test_refractory();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 21'h000400, 1'b0);
            checks++; if (refrac_busy !== 1'b1) begin errors++; $display("FAIL refrac_busy%0d: got %b want 1", i, refrac_busy); end
            checks++; if (spike !== 1'b0) begin errors++; $display("FAIL refrac_spike%0d: got %b want 0", i, spike); end
            drive(1'b0, 21'h000000, 1'b1);
            checks++; if (v_out !== 21'h000000) begin errors++; $display("FAIL refrac_v%0d: got %h want 000000", i, v_out); end
            checks++; if (v_valid !== 1'b1) begin errors++; $display("FAIL refrac_valid%0d: got %b want 1", i, v_valid); end
        end
        checks++; if (refrac_busy !== 1'b0) begin errors++; $display("FAIL refrac_exit: got %b want 0", refrac_busy); end
        drive(1'b1, 21'h000200, 1'b1);
        checks++; if (v_out !== 21'h000200) begin errors++; $display("FAIL post_refrac_v: got %h want 000200", v_out); end
    endtask

    task automatic test_saturation();
        do_reset();
        v_thresh = 21'h0FFFFF;
        v_reset  = 21'h000000;
        drive(1'b1, 21'h0FF000, 1'b1);
        checks++; if (v_out !== 21'h0FF000) begin errors++; $display("FAIL sat_pre_v: got %h want 0ff000", v_out); end
        drive(1'b1, 21'h0FFFFF, 1'b1);
        checks++; if (v_out !== 21'h0FFFFF) begin errors++; $display("FAIL sat_pos_v: got %h want 0fffff", v_out); end
        drive(1'b0, 21'h000000, 1'b0);
        checks++; if (spike !== 1'b1) begin errors++; $display("FAIL sat_spike: got %b want 1", spike); end
        do_reset();
        drive(1'b1, 21'h100800, 1'b1);
        checks++; if (v_out !== 21'h100800) begin errors++; $display("FAIL sat_neg_pre: got %h want 100800", v_out); end
        drive(1'b1, 21'h100000, 1'b1);
        checks++; if (v_out !== 21'h100000) begin errors++; $display("FAIL sat_neg_v: got %h want 100000", v_out); end
        drive(1'b0, 21'h000000, 1'b0);
        checks++; if (spike !== 1'b0) begin errors++; $display("FAIL sat_neg_spike: got %b want 0", spike); end
    endtask

    task automatic test_reset_mid_refrac();
        do_reset();
        v_thresh = 21'h000200;
        v_reset  = 21'h000000;
        drive(1'b1, 21'h000200, 1'b1);
        drive(1'b0, 21'h000000, 1'b0);
        checks++; if (spike !== 1'b1) begin errors++; $display("FAIL mid_spike: got %b want 1", spike); end
        drive(1'b0, 21'h000000, 1'b1);
        drive(1'b0, 21'h000000, 1'b1);
        checks++; if (refrac_busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", refrac_busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (refrac_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", refrac_busy); end
        checks++; if (v_out !== 21'h000000) begin errors++; $display("FAIL mid_rst_v: got %h want 000000", v_out); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v_thresh = 21'h000A00;
        @(posedge clk);
        #1;
        checks++; if (spike !== 1'b0) begin errors++; $display("FAIL mid_rel_spike: got %b want 0", spike); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rel_ready: got %b want 1", bus.in_ready); end
        drive(1'b1, 21'h000200, 1'b1);
        checks++; if (v_out !== 21'h000200) begin errors++; $display("FAIL mid_after_v: got %h want 000200", v_out); end
        checks++; if (refrac_busy !== 1'b0) begin errors++; $display("FAIL mid_after_busy: got %b want 0", refrac_busy); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        step = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_current = 21'h000000;
        v_thresh = 21'h000A00;
        v_reset = 21'h000000;
        test_reset();
        test_integrate();
        test_fire();
        test_refractory();
        test_saturation();
        test_reset_mid_refrac();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
